// File: rtl/perm_pkg.sv
// Shared types for the SPU odd-pipe permute unit: op codes, internal stage
// modes and the per-byte crossbar select word.
package perm_pkg;

    localparam int unsigned QW     = 128;
    localparam int unsigned NBYTES = QW / 8;

    typedef enum logic [3:0] {
        NOP      = 4'd0,
        SHLQBY   = 4'd1,
        SHLQBYI  = 4'd2,
        SHLQBYBI = 4'd3,
        ROTQBY   = 4'd4,
        ROTQBYI  = 4'd5,
        ROTQBYBI = 4'd6,
        ROTQMBY  = 4'd7,
        ROTQMBYI = 4'd8,
        SHLQBI   = 4'd9,
        SHLQBII  = 4'd10,
        ROTQBI   = 4'd11,
        ROTQBII  = 4'd12,
        SHUFB    = 4'd13
    } perm_op_t;

    typedef enum logic [2:0] {
        ByNone,
        ByShl,
        ByRot,
        ByShr,
        ByShuf
    } byte_mode_t;

    typedef enum logic [1:0] {
        BiNone,
        BiShl,
        BiRot
    } bit_mode_t;

    // One output byte: either a fill constant or byte src of {a,b} (0 = a byte 0).
    typedef struct packed {
        logic       fill_en;
        logic [7:0] fill;
        logic [4:0] src;
    } xbar_sel_t;

endpackage

// File: rtl/perm_byte_xbar.sv
// Combinational 16-byte crossbar: each output byte picks one of the 32 bytes of
// {src_a, src_b} or a fill constant. Byte 0 is the most significant byte.
module perm_byte_xbar
    import perm_pkg::*;
(
    input  logic      [QW-1:0]     src_a,
    input  logic      [QW-1:0]     src_b,
    input  xbar_sel_t [NBYTES-1:0] sel,
    output logic      [QW-1:0]     dout
);

    logic [2*QW-1:0] cat;

    assign cat = {src_a, src_b};

    always_comb begin
        dout = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (sel[i].fill_en) begin
                dout[8*(NBYTES-1-i) +: 8] = sel[i].fill;
            end else begin
                dout[8*(NBYTES-1-i) +: 8] = cat[8*(2*NBYTES-1-int'(sel[i].src)) +: 8];
            end
        end
    end

endmodule

// File: rtl/perm_pipe.sv
// 4-stage permute/shift unit: S1 decode + count, S2 byte crossbar, S3 bit
// shift/rotate, S4 output register. No backpressure; flush kills all in-flight ops.
module perm_pipe
    import perm_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned RADDR = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  perm_op_t               in_op,
    input  logic [QW-1:0]          in_ra,
    input  logic [QW-1:0]          in_rb,
    input  logic [QW-1:0]          in_rc,
    input  logic [6:0]             in_imm,
    input  logic [RADDR-1:0]       in_rt,
    input  logic                   flush,
    output logic                   wb_valid,
    output logic [RADDR-1:0]       wb_rt,
    output logic [QW-1:0]          wb_result,
    output logic [DEPTH-1:0]       stg_valid,
    output logic [DEPTH*RADDR-1:0] stg_rt
);

    // Architectural bit k is vector bit QW-1-k, so rb[27:31] is in_rb[100:96]
    // and imm[2:6] is in_imm[4:0].
    logic       dec_legal;
    byte_mode_t dec_bmode;
    logic [4:0] dec_bs;
    bit_mode_t  dec_imode;
    logic [2:0] dec_is;
    logic       unused_imm;

    assign unused_imm = ^in_imm[6:5];

    always_comb begin
        dec_legal = 1'b1;
        dec_bmode = ByNone;
        dec_bs    = '0;
        dec_imode = BiNone;
        dec_is    = '0;
        case (in_op)
            SHLQBY:   begin dec_bmode = ByShl;  dec_bs = in_rb[100:96];          end
            SHLQBYI:  begin dec_bmode = ByShl;  dec_bs = in_imm[4:0];            end
            SHLQBYBI: begin dec_bmode = ByShl;  dec_bs = in_rb[103:99];          end
            ROTQBY:   begin dec_bmode = ByRot;  dec_bs = {1'b0, in_rb[99:96]};   end
            ROTQBYI:  begin dec_bmode = ByRot;  dec_bs = {1'b0, in_imm[3:0]};    end
            ROTQBYBI: begin dec_bmode = ByRot;  dec_bs = {1'b0, in_rb[102:99]};  end
            ROTQMBY:  begin dec_bmode = ByShr;  dec_bs = 5'd0 - in_rb[100:96];   end
            ROTQMBYI: begin dec_bmode = ByShr;  dec_bs = 5'd0 - in_imm[4:0];     end
            SHLQBI:   begin dec_imode = BiShl;  dec_is = in_rb[98:96];           end
            SHLQBII:  begin dec_imode = BiShl;  dec_is = in_imm[2:0];            end
            ROTQBI:   begin dec_imode = BiRot;  dec_is = in_rb[98:96];           end
            ROTQBII:  begin dec_imode = BiRot;  dec_is = in_imm[2:0];            end
            SHUFB:    begin dec_bmode = ByShuf;                                  end
            default:  dec_legal = 1'b0;
        endcase
    end

    logic                 s1_valid, s2_valid, s3_valid;
    logic [RADDR-1:0]     s1_rt, s2_rt, s3_rt;
    byte_mode_t           s1_bmode;
    logic [4:0]           s1_bs;
    bit_mode_t            s1_imode, s2_imode;
    logic [2:0]           s1_is, s2_is;
    logic [QW-1:0]        s1_ra, s1_rb, s1_rc, s2_data, s3_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            wb_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            wb_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid & dec_legal;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            wb_valid <= s3_valid;
        end
    end

    // S2: build per-byte crossbar selects from the decoded byte mode.
    xbar_sel_t [NBYTES-1:0] xsel;
    logic      [7:0]        ctl;
    logic      [QW-1:0]     xbar_out;

    always_comb begin
        xsel = '0;
        ctl  = '0;
        for (int i = 0; i < NBYTES; i++) begin
            ctl = s1_rc[8*(NBYTES-1-i) +: 8];
            case (s1_bmode)
                ByShl: begin
                    if (int'(s1_bs) + i > NBYTES - 1) xsel[i].fill_en = 1'b1;
                    else                              xsel[i].src = 5'(int'(s1_bs) + i);
                end
                ByShr: begin
                    if (int'(s1_bs) > i) xsel[i].fill_en = 1'b1;
                    else                 xsel[i].src = 5'(i - int'(s1_bs));
                end
                ByRot: xsel[i].src = {1'b0, 4'(i) + s1_bs[3:0]};
                ByShuf: begin
                    if (ctl[7:6] == 2'b10) begin
                        xsel[i].fill_en = 1'b1;
                    end else if (ctl[7:5] == 3'b110) begin
                        xsel[i].fill_en = 1'b1;
                        xsel[i].fill    = 8'hFF;
                    end else if (ctl[7:5] == 3'b111) begin
                        xsel[i].fill_en = 1'b1;
                        xsel[i].fill    = 8'h80;
                    end else begin
                        xsel[i].src = ctl[4:0];
                    end
                end
                default: xsel[i].src = 5'(i);
            endcase
        end
    end

    perm_byte_xbar u_xbar (
        .src_a (s1_ra),
        .src_b (s1_rb),
        .sel   (xsel),
        .dout  (xbar_out)
    );

    // S3: shifting a doubled word lets shift and rotate share one shifter.
    logic [QW-1:0]   bit_lo;
    logic [2*QW-1:0] bit_dbl;
    logic [QW-1:0]   bit_out;

    always_comb begin
        bit_lo  = (s2_imode == BiRot) ? s2_data : '0;
        bit_dbl = {s2_data, bit_lo} << s2_is;
        bit_out = (s2_imode == BiNone) ? s2_data : bit_dbl[2*QW-1 -: QW];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_rt     <= '0;
            s1_bmode  <= ByNone;
            s1_bs     <= '0;
            s1_imode  <= BiNone;
            s1_is     <= '0;
            s1_ra     <= '0;
            s1_rb     <= '0;
            s1_rc     <= '0;
            s2_rt     <= '0;
            s2_imode  <= BiNone;
            s2_is     <= '0;
            s2_data   <= '0;
            s3_rt     <= '0;
            s3_data   <= '0;
            wb_rt     <= '0;
            wb_result <= '0;
        end else begin
            s1_rt     <= in_rt;
            s1_bmode  <= dec_bmode;
            s1_bs     <= dec_bs;
            s1_imode  <= dec_imode;
            s1_is     <= dec_is;
            s1_ra     <= in_ra;
            s1_rb     <= in_rb;
            s1_rc     <= in_rc;
            s2_rt     <= s1_rt;
            s2_imode  <= s1_imode;
            s2_is     <= s1_is;
            s2_data   <= xbar_out;
            s3_rt     <= s2_rt;
            s3_data   <= bit_out;
            wb_rt     <= s3_rt;
            wb_result <= s3_data;
        end
    end

    assign stg_valid = {wb_valid, s3_valid, s2_valid, s1_valid};
    assign stg_rt    = {wb_rt, s3_rt, s2_rt, s1_rt};

endmodule

// File: tb/tb_perm_pipe.sv
// Scoreboard bench for perm_pipe: a driver pushes expected results from a
// shift/array reference model; a monitor pops and compares on wb_valid.
module tb_perm_pipe;
    import perm_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    perm_op_t       in_op;
    logic [127:0]   in_ra, in_rb, in_rc;
    logic [6:0]     in_imm;
    logic [6:0]     in_rt;
    logic           flush;
    logic           wb_valid;
    logic [6:0]     wb_rt;
    logic [127:0]   wb_result;
    logic [3:0]     stg_valid;
    logic [27:0]    stg_rt;

    perm_pipe #(.DEPTH(4), .RADDR(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_op     (in_op),
        .in_ra     (in_ra),
        .in_rb     (in_rb),
        .in_rc     (in_rc),
        .in_imm    (in_imm),
        .in_rt     (in_rt),
        .flush     (flush),
        .wb_valid  (wb_valid),
        .wb_rt     (wb_rt),
        .wb_result (wb_result),
        .stg_valid (stg_valid),
        .stg_rt    (stg_rt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] res;
        logic [6:0]   rt;
        int           due;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         edge_cnt = 0;
    bit         eff_v  [4096];
    logic [6:0] eff_rt [4096];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [127:0] rotl(input logic [127:0] v, input int n);
        return (n == 0) ? v : ((v << n) | (v >> (128 - n)));
    endfunction

    // Reference: architectural rules written with plain shifts and byte arrays.
    function automatic logic [127:0] model(input perm_op_t op, input logic [127:0] ra,
                                           input logic [127:0] rb, input logic [127:0] rc,
                                           input logic [6:0] imm);
        int unsigned  w = rb[127:96];
        int unsigned  iv = 32'(imm);
        int           s;
        logic [7:0]   src [32];
        logic [7:0]   c;
        logic [127:0] r = '0;
        case (op)
            SHLQBY, SHLQBYI, SHLQBYBI: begin
                s = (op == SHLQBY) ? int'(w % 32) : (op == SHLQBYI) ? int'(iv % 32)
                                                                    : int'((w / 8) % 32);
                r = (s > 15) ? '0 : ra << (8 * s);
            end
            ROTQBY, ROTQBYI, ROTQBYBI: begin
                s = (op == ROTQBY) ? int'(w % 16) : (op == ROTQBYI) ? int'(iv % 16)
                                                                    : int'((w / 8) % 16);
                r = rotl(ra, 8 * s);
            end
            ROTQMBY, ROTQMBYI: begin
                s = (op == ROTQMBY) ? int'(w % 32) : int'(iv % 32);
                s = (32 - s) % 32;
                r = (s > 15) ? '0 : ra >> (8 * s);
            end
            SHLQBI:  r = ra << (w % 8);
            SHLQBII: r = ra << (iv % 8);
            ROTQBI:  r = rotl(ra, int'(w % 8));
            ROTQBII: r = rotl(ra, int'(iv % 8));
            SHUFB: begin
                for (int j = 0; j < 16; j++) begin
                    src[j]      = ra[127 - 8*j -: 8];
                    src[j + 16] = rb[127 - 8*j -: 8];
                end
                for (int i = 0; i < 16; i++) begin
                    c = rc[127 - 8*i -: 8];
                    if (c[7:6] == 2'b10)       r[127 - 8*i -: 8] = 8'h00;
                    else if (c[7:5] == 3'b110) r[127 - 8*i -: 8] = 8'hFF;
                    else if (c[7:5] == 3'b111) r[127 - 8*i -: 8] = 8'h80;
                    else                       r[127 - 8*i -: 8] = src[c[4:0]];
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic issue(input perm_op_t op, input logic [127:0] ra, input logic [127:0] rb,
                         input logic [127:0] rc, input logic [6:0] imm, input logic [6:0] rt,
                         input bit v, input bit fl, input bit use_exp,
                         input logic [127:0] exp_res);
        int n;
        exp_t e;
        @(negedge clk);
        in_valid = v;
        in_op    = op;
        in_ra    = ra;
        in_rb    = rb;
        in_rc    = rc;
        in_imm   = imm;
        in_rt    = rt;
        flush    = fl;
        n = edge_cnt + 1;
        if (fl) begin
            // Everything still inside the pipe after this edge dies.
            while (sb.size() > 0 && sb[$].due >= n) void'(sb.pop_back());
            for (int k = n - 3; k < n; k++) if (k >= 0) eff_v[k] = 1'b0;
        end else if (v && int'(op) >= 1 && int'(op) <= 13) begin
            e.res = use_exp ? exp_res : model(op, ra, rb, rc, imm);
            e.rt  = rt;
            e.due = n + 3;
            sb.push_back(e);
            eff_v[n]  = 1'b1;
            eff_rt[n] = rt;
        end
    endtask

    task automatic idle();
        issue(NOP, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic rand_op(input bit allow_flush);
        issue(perm_op_t'($urandom_range(0, 15)),
              {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom},
              7'($urandom), 7'($urandom), ($urandom_range(0, 9) != 0),
              allow_flush && ($urandom_range(0, 39) == 0), 1'b0, '0);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        logic [3:0]  exp_v;
        logic [27:0] exp_r, act_r;
        int n;
        forever begin
            @(posedge clk);
            #1;
            edge_cnt++;
            while (sb.size() > 0 && sb[0].due < edge_cnt) begin
                chk("wb_late", 128'(edge_cnt), 128'(sb[0].due));
                void'(sb.pop_front());
            end
            if (wb_valid) begin
                if (sb.size() == 0) begin
                    chk("wb_unexpected", 128'(wb_valid), 128'(0));
                end else begin
                    e = sb.pop_front();
                    chk("wb_due", 128'(edge_cnt), 128'(e.due));
                    chk("wb_rt", 128'(wb_rt), 128'(e.rt));
                    chk("wb_result", wb_result, e.res);
                end
            end else if (sb.size() > 0 && sb[0].due == edge_cnt) begin
                chk("wb_missing", 128'(wb_valid), 128'(1));
                void'(sb.pop_front());
            end
            exp_v = '0;
            exp_r = '0;
            act_r = '0;
            for (int s = 0; s < 4; s++) begin
                n = edge_cnt - s;
                if (n >= 0 && n < 4096 && eff_v[n]) begin
                    exp_v[s] = 1'b1;
                    exp_r[7*s +: 7] = eff_rt[n];
                end
                if (stg_valid[s]) act_r[7*s +: 7] = stg_rt[7*s +: 7];
            end
            chk("stg", 128'({act_r, stg_valid}), 128'({exp_r, exp_v}));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    localparam logic [127:0] RA1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] RA3 = 128'h80000000_00000000_00000000_00000001;
    localparam logic [127:0] RA4 = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    localparam logic [127:0] RB4 = 128'h10111213_14151617_18191A1B_1C1D1E1F;
    localparam logic [127:0] RC4 = 128'h1F0080C0_E010050F_1AA0FFDF_11070302;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_op    = NOP;
        in_ra    = '0;
        in_rb    = '0;
        in_rc    = '0;
        in_imm   = '0;
        in_rt    = '0;
        flush    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wb_valid", 128'(wb_valid), 128'(0));
        chk("rst_wb_rt", 128'(wb_rt), 128'(0));
        chk("rst_wb_result", wb_result, 128'(0));
        chk("rst_stg_valid", 128'(stg_valid), 128'(0));
        chk("rst_stg_rt", 128'(stg_rt), 128'(0));
        reset = 1'b0;

        // Directed vectors with hand-computed results.
        issue(SHLQBY, RA1, 128'd3 << 96, '0, '0, 7'd5, 1'b1, 1'b0, 1'b1,
              128'h33445566_778899AA_BBCCDDEE_FF000000);
        issue(SHLQBY, RA1, 128'd16 << 96, '0, '0, 7'd6, 1'b1, 1'b0, 1'b1, '0);
        issue(SHLQBY, RA1, 128'd0, '0, '0, 7'd7, 1'b1, 1'b0, 1'b1, RA1);
        issue(ROTQMBYI, RA1, '0, '0, 7'h7E, 7'd8, 1'b1, 1'b0, 1'b1,
              128'h00000011_22334455_66778899_AABBCCDD);
        issue(SHLQBI, RA3, 128'd1 << 96, '0, '0, 7'd9, 1'b1, 1'b0, 1'b1, 128'd2);
        issue(ROTQBI, RA3, 128'd1 << 96, '0, '0, 7'd10, 1'b1, 1'b0, 1'b1, 128'd3);
        issue(SHUFB, RA4, RB4, RC4, '0, 7'd11, 1'b1, 1'b0, 1'b1,
              128'h1F0000FF_8010050F_1A0080FF_11070302);
        issue(perm_op_t'(4'd14), RA1, '0, '0, '0, 7'd12, 1'b1, 1'b0, 1'b0, '0);
        issue(NOP, RA1, '0, '0, '0, 7'd13, 1'b1, 1'b0, 1'b0, '0);
        repeat (6) idle();

        // Six back-to-back ops; flush lands with the sixth, so only 1-2 write.
        for (int i = 0; i < 6; i++) begin
            issue(ROTQBYI, RA1, '0, '0, 7'(i + 1), 7'(20 + i), 1'b1, (i == 5), 1'b0, '0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_stg_valid", 128'(stg_valid), 128'(0));
        chk("flush_wb_valid", 128'(wb_valid), 128'(0));
        repeat (5) idle();

        // Random traffic with occasional flushes and one async reset pulse.
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                @(negedge clk);
                in_valid = 1'b0;
                flush    = 1'b0;
                #2 reset = 1'b1;
                #1;
                chk("areset_wb_valid", 128'(wb_valid), 128'(0));
                chk("areset_stg_valid", 128'(stg_valid), 128'(0));
                sb.delete();
                for (int k = edge_cnt - 3; k <= edge_cnt; k++) if (k >= 0) eff_v[k] = 1'b0;
                #1 reset = 1'b0;
                issue(SHLQBYI, RA1, '0, '0, 7'd1, 7'd99, 1'b1, 1'b0, 1'b0, '0);
            end else begin
                rand_op(1'b1);
            end
        end
        repeat (8) idle();
        chk("drain", 128'(sb.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
